// File: rtl/fb_access_arbiter_if.sv
// ---------------------------------------------------------------------------
// fb_access_arbiter_if
//
// Bundles every non-clock, non-reset signal of fb_access_arbiter: the
// display read path, the sensor write path, the BRAM port and the status
// outputs. Signal names keep the i_/o_ prefixes as seen from the arbiter.
//
//   slave  : the arbiter side (drives o_*, samples i_*)
//   master : the surrounding system / bench (drives i_*, samples o_*)
//
// Display read : i_frame, i_rd_req, i_rd_addr -> o_rd_valid, o_rd_data
// Sensor write : i_wr_valid, i_wr_addr, i_wr_data, i_wr_last -> o_wr_ready
// BRAM port    : o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata <- i_mem_rdata
// Status       : o_disp_bank, o_stale_cnt, o_addr_err
// ---------------------------------------------------------------------------
interface fb_access_arbiter_if #(
  parameter int p_addr_width = 15,
  parameter int p_data_width = 8
);

  // display read path
  logic                    i_frame;
  logic                    i_rd_req;
  logic [p_addr_width-1:0] i_rd_addr;
  logic                    o_rd_valid;
  logic [p_data_width-1:0] o_rd_data;

  // sensor write path
  logic                    i_wr_valid;
  logic [p_addr_width-1:0] i_wr_addr;
  logic [p_data_width-1:0] i_wr_data;
  logic                    i_wr_last;
  logic                    o_wr_ready;

  // BRAM port; o_mem_addr MSB selects the bank
  logic                    o_mem_en;
  logic                    o_mem_we;
  logic [p_addr_width:0]   o_mem_addr;
  logic [p_data_width-1:0] o_mem_wdata;
  logic [p_data_width-1:0] i_mem_rdata;

  // status
  logic                    o_disp_bank;
  logic [7:0]              o_stale_cnt;
  logic                    o_addr_err;

  modport slave (
    input  i_frame, i_rd_req, i_rd_addr,
    input  i_wr_valid, i_wr_addr, i_wr_data, i_wr_last,
    input  i_mem_rdata,
    output o_rd_valid, o_rd_data, o_wr_ready,
    output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    output o_disp_bank, o_stale_cnt, o_addr_err
  );

  modport master (
    output i_frame, i_rd_req, i_rd_addr,
    output i_wr_valid, i_wr_addr, i_wr_data, i_wr_last,
    output i_mem_rdata,
    input  o_rd_valid, o_rd_data, o_wr_ready,
    input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
    input  o_disp_bank, o_stale_cnt, o_addr_err
  );

endinterface

// File: rtl/fb_access_arbiter.sv
// ---------------------------------------------------------------------------
// fb_access_arbiter
//
// Shares one single-port framebuffer BRAM between the display read path
// (pixel rate, fixed latency, never stalled) and the thermal-sensor write
// path (160x120 frames, valid/ready). The writer only gets cycles the display
// leaves idle. With ping-pong buffering the writer fills the hidden bank and
// the banks swap on the next display frame start after a complete sensor
// frame, so a half-written frame is never shown.
//
// Build option:
//   FB_DOUBLE_BUFFER_EN  defined   : ping-pong banks, WRITE/HOLD handshake,
//                                    stale-frame counter.
//                        undefined : single bank; bank bit and o_disp_bank
//                                    are 0, i_wr_last and i_frame are
//                                    ignored, o_stale_cnt stays 0.
//
// Ports:
//   i_clk_pixel  pixel clock
//   i_rst        synchronous active-high reset
//   bus          fb_access_arbiter_if.slave
//                  display : i_frame, i_rd_req, i_rd_addr, o_rd_valid, o_rd_data
//                  writer  : i_wr_valid, i_wr_addr, i_wr_data, i_wr_last, o_wr_ready
//                  BRAM    : o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, i_mem_rdata
//                  status  : o_disp_bank, o_stale_cnt, o_addr_err
// ---------------------------------------------------------------------------
module fb_access_arbiter #(
  parameter int p_addr_width = 15,
  parameter int p_data_width = 8,
  parameter int p_fb_pixels  = 19200,
  parameter int p_rd_latency = 1
) (
  input logic                i_clk_pixel,
  input logic                i_rst,
  fb_access_arbiter_if.slave bus
);

  typedef enum logic [0:0] {
    ST_WRITE = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  localparam logic [p_addr_width:0] lp_fb_pixels = (p_addr_width + 1)'(p_fb_pixels);

  // control state
  state_t     state_q, state_d;
  logic       disp_bank_q, disp_bank_d;
  logic       wr_bank_q, wr_bank_d;
  logic [7:0] stale_q, stale_d;
  logic       addr_err_q;

  // read-valid shift register, one stage per cycle of command + BRAM latency
  logic [p_rd_latency:0] vld_p;

  // registered BRAM command
  logic                    mem_en_p0;
  logic                    mem_we_p0;
  logic [p_addr_width:0]   mem_addr_p0;
  logic [p_data_width-1:0] mem_wdata_p0;

  logic wr_ready;
  logic wr_acc;
  logic wr_addr_ok;
  logic rd_bank_sel;
  logic wr_bank_sel;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Display has absolute priority; in HOLD the finished frame must not be
  // overwritten, so the writer is stalled until the swap.
  assign wr_ready   = !bus.i_rd_req && (state_q == ST_WRITE);
  assign wr_acc     = bus.i_wr_valid && wr_ready;
  assign wr_addr_ok = ({1'b0, bus.i_wr_addr} < lp_fb_pixels);

`ifdef FB_DOUBLE_BUFFER_EN
  logic frame_done;

  assign frame_done  = wr_acc && bus.i_wr_last;
  assign rd_bank_sel = disp_bank_q;
  assign wr_bank_sel = wr_bank_q;

  // A frame start swaps only once the writer has completed a frame. When the
  // last beat and the frame start coincide the swap still happens now; the
  // beat's command was formed from the pre-swap wr_bank, so it lands in the
  // frame that becomes visible.
  always_comb begin
    state_d     = state_q;
    disp_bank_d = disp_bank_q;
    wr_bank_d   = wr_bank_q;
    stale_d     = stale_q;
    unique case (state_q)
      ST_WRITE: begin
        if (bus.i_frame && frame_done) begin
          disp_bank_d = wr_bank_q;
          wr_bank_d   = disp_bank_q;
          stale_d     = 8'd0;
        end else if (bus.i_frame) begin
          stale_d = sat_inc8(stale_q);
        end else if (frame_done) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.i_frame) begin
          disp_bank_d = wr_bank_q;
          wr_bank_d   = disp_bank_q;
          stale_d     = 8'd0;
          state_d     = ST_WRITE;
        end
      end
      default: state_d = ST_WRITE;
    endcase
  end
`else
  // Single bank: frame boundaries carry no meaning for the arbiter.
  logic unused_frame_sigs;

  assign unused_frame_sigs = ^{bus.i_frame, bus.i_wr_last};
  assign rd_bank_sel       = 1'b0;
  assign wr_bank_sel       = 1'b0;

  always_comb begin
    state_d     = ST_WRITE;
    disp_bank_d = disp_bank_q;
    wr_bank_d   = wr_bank_q;
    stale_d     = stale_q;
  end
`endif

  always_ff @(posedge i_clk_pixel) begin
    if (i_rst) begin
      state_q     <= ST_WRITE;
      disp_bank_q <= 1'b0;
      wr_bank_q   <= 1'b1;
      stale_q     <= 8'd0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      disp_bank_q <= disp_bank_d;
      wr_bank_q   <= wr_bank_d;
      stale_q     <= stale_d;
      if (wr_acc && !wr_addr_ok) begin
        addr_err_q <= 1'b1;
      end
    end
  end

  // ---- stage p0: BRAM command register ----
  // Out-of-range writes are consumed without touching the BRAM; address and
  // data keep their previous values whenever no access is issued.
  always_ff @(posedge i_clk_pixel) begin
    if (i_rst) begin
      mem_en_p0    <= 1'b0;
      mem_we_p0    <= 1'b0;
      mem_addr_p0  <= '0;
      mem_wdata_p0 <= '0;
    end else if (bus.i_rd_req) begin
      mem_en_p0   <= 1'b1;
      mem_we_p0   <= 1'b0;
      mem_addr_p0 <= {rd_bank_sel, bus.i_rd_addr};
    end else if (wr_acc && wr_addr_ok) begin
      mem_en_p0    <= 1'b1;
      mem_we_p0    <= 1'b1;
      mem_addr_p0  <= {wr_bank_sel, bus.i_wr_addr};
      mem_wdata_p0 <= bus.i_wr_data;
    end else begin
      mem_en_p0 <= 1'b0;
      mem_we_p0 <= 1'b0;
    end
  end

  // ---- stages p0..pN: read-valid pipeline ----
  always_ff @(posedge i_clk_pixel) begin
    if (i_rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= bus.i_rd_req;
      for (int k = 1; k <= p_rd_latency; k++) begin
        vld_p[k] <= vld_p[k-1];
      end
    end
  end

  assign bus.o_wr_ready  = wr_ready;
  assign bus.o_rd_valid  = vld_p[p_rd_latency];
  assign bus.o_rd_data   = bus.i_mem_rdata;
  assign bus.o_mem_en    = mem_en_p0;
  assign bus.o_mem_we    = mem_we_p0;
  assign bus.o_mem_addr  = mem_addr_p0;
  assign bus.o_mem_wdata = mem_wdata_p0;
  assign bus.o_disp_bank = disp_bank_q;
  assign bus.o_stale_cnt = stale_q;
  assign bus.o_addr_err  = addr_err_q;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fb_access_arbiter
//
// Bench for fb_access_arbiter: a table of single-cycle vectors from reset,
// hand-written multi-cycle sequences (full frame, bank swap, stale counter,
// address error, coincident last/frame, reset abort) and a randomized run
// compared with a frame-level reference model. Expectations follow the
// build selected by FB_DOUBLE_BUFFER_EN.
// ---------------------------------------------------------------------------
module tb_fb_access_arbiter;

  localparam int AW  = 15;
  localparam int DW  = 8;
  localparam int PIX = 19200;
  localparam int LAT = 1;

`ifdef FB_DOUBLE_BUFFER_EN
  localparam bit DBL = 1'b1;
`else
  localparam bit DBL = 1'b0;
`endif

  // address offset of the bank the writer uses right after reset
  localparam int WB = DBL ? 32768 : 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fb_access_arbiter_if #(.p_addr_width(AW), .p_data_width(DW)) bus ();

  fb_access_arbiter #(
    .p_addr_width(AW),
    .p_data_width(DW),
    .p_fb_pixels (PIX),
    .p_rd_latency(LAT)
  ) dut (
    .i_clk_pixel(clk),
    .i_rst      (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic set_idle();
    bus.i_frame     = 1'b0;
    bus.i_rd_req    = 1'b0;
    bus.i_rd_addr   = '0;
    bus.i_wr_valid  = 1'b0;
    bus.i_wr_addr   = '0;
    bus.i_wr_data   = '0;
    bus.i_wr_last   = 1'b0;
    bus.i_mem_rdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wr_beat(input int addr, input int data, input bit last, input bit frame);
    bus.i_wr_valid = 1'b1;
    bus.i_wr_addr  = AW'(addr);
    bus.i_wr_data  = DW'(data);
    bus.i_wr_last  = last;
    bus.i_frame    = frame;
    step();
    set_idle();
  endtask

  task automatic pulse_frame(input int n);
    for (int i = 0; i < n; i++) begin
      bus.i_frame = 1'b1;
      step();
      bus.i_frame = 1'b0;
      step();
    end
  endtask

  typedef struct {
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          exp_ready;
    logic          exp_en;
    logic          exp_we;
    logic [AW:0]   exp_addr;
    logic [DW-1:0] exp_wdata;
    logic          exp_vld;
    logic          exp_err;
  } vec_t;

  vec_t vecs[9];

  // reference model state for the randomized run
  bit m_disp, m_wr, m_hold, m_err, m_en, m_we, m_ready, m_acc, m_vld, r_rst;
  int m_stale, m_addr, m_wdata, e, wcnt;
  int due[$];

  initial begin
    set_idle();
    step();
    step();
    step();
    rst = 1'b0;

    // ---------------- reset state ----------------
    chk("rst_wr_ready",  32'(bus.o_wr_ready), 32'd1);
    chk("rst_mem_en",    32'(bus.o_mem_en), 32'd0);
    chk("rst_mem_we",    32'(bus.o_mem_we), 32'd0);
    chk("rst_mem_addr",  32'(bus.o_mem_addr), 32'd0);
    chk("rst_rd_valid",  32'(bus.o_rd_valid), 32'd0);
    chk("rst_disp_bank", 32'(bus.o_disp_bank), 32'd0);
    chk("rst_stale",     32'(bus.o_stale_cnt), 32'd0);
    chk("rst_addr_err",  32'(bus.o_addr_err), 32'd0);

    // ---------------- table-driven vectors (consecutive cycles) ----------------
    vecs[0] = '{1'b1, 15'd5,     1'b1, 15'd7,     8'hA5, 1'b0, 1'b1, 1'b0, 16'(5),          8'h00, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 15'd5,     1'b1, 15'd7,     8'hA5, 1'b0, 1'b1, 1'b0, 16'(5),          8'h00, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 15'd5,     1'b1, 15'd7,     8'hA5, 1'b0, 1'b1, 1'b0, 16'(5),          8'h00, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 15'd5,     1'b1, 15'd7,     8'hA5, 1'b0, 1'b1, 1'b0, 16'(5),          8'h00, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 15'd0,     1'b1, 15'd7,     8'hA5, 1'b1, 1'b1, 1'b1, 16'(WB + 7),     8'hA5, 1'b1, 1'b0};
    vecs[5] = '{1'b0, 15'd0,     1'b0, 15'd0,     8'h00, 1'b1, 1'b0, 1'b0, 16'(WB + 7),     8'hA5, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 15'd0,     1'b1, 15'd19200, 8'h11, 1'b1, 1'b0, 1'b0, 16'(WB + 7),     8'hA5, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 15'd0,     1'b1, 15'd19199, 8'h3C, 1'b1, 1'b1, 1'b1, 16'(WB + 19199), 8'h3C, 1'b0, 1'b1};
    vecs[8] = '{1'b1, 15'h7FFF,  1'b0, 15'd0,     8'h00, 1'b0, 1'b1, 1'b0, 16'h7FFF,        8'h3C, 1'b0, 1'b1};

    for (int i = 0; i < 9; i++) begin
      bus.i_rd_req   = vecs[i].rd_req;
      bus.i_rd_addr  = vecs[i].rd_addr;
      bus.i_wr_valid = vecs[i].wr_valid;
      bus.i_wr_addr  = vecs[i].wr_addr;
      bus.i_wr_data  = vecs[i].wr_data;
      #1;
      chk($sformatf("vec%0d_wr_ready", i), 32'(bus.o_wr_ready), 32'(vecs[i].exp_ready));
      step();
      chk($sformatf("vec%0d_mem_en", i),    32'(bus.o_mem_en),    32'(vecs[i].exp_en));
      chk($sformatf("vec%0d_mem_we", i),    32'(bus.o_mem_we),    32'(vecs[i].exp_we));
      chk($sformatf("vec%0d_mem_addr", i),  32'(bus.o_mem_addr),  32'(vecs[i].exp_addr));
      chk($sformatf("vec%0d_mem_wdata", i), 32'(bus.o_mem_wdata), 32'(vecs[i].exp_wdata));
      chk($sformatf("vec%0d_rd_valid", i),  32'(bus.o_rd_valid),  32'(vecs[i].exp_vld));
      chk($sformatf("vec%0d_addr_err", i),  32'(bus.o_addr_err),  32'(vecs[i].exp_err));
    end
    set_idle();

    // address error is sticky until reset
    for (int i = 0; i < 20; i++) step();
    chk("err_sticky", 32'(bus.o_addr_err), 32'd1);
    do_reset();
    chk("err_cleared_by_rst", 32'(bus.o_addr_err), 32'd0);

    // ---------------- full sensor frame, then swap ----------------
    wcnt = 0;
    for (int i = 0; i < PIX; i++) begin
      bus.i_wr_valid = 1'b1;
      bus.i_wr_addr  = AW'(i);
      bus.i_wr_data  = DW'(i);
      bus.i_wr_last  = (i == PIX - 1);
      step();
      if (bus.o_mem_we === 1'b1) wcnt++;
    end
    chk("frame_last_addr", 32'(bus.o_mem_addr), 32'(WB + PIX - 1));
    set_idle();
    #1;
    chk("frame_writes", 32'(wcnt), 32'(PIX));
    chk("hold_wr_ready", 32'(bus.o_wr_ready), 32'(!DBL));
    pulse_frame(1);
    chk("swap_disp_bank", 32'(bus.o_disp_bank), 32'(DBL));
    chk("swap_stale",     32'(bus.o_stale_cnt), 32'd0);
    chk("swap_wr_ready",  32'(bus.o_wr_ready), 32'd1);
    bus.i_rd_req  = 1'b1;
    bus.i_rd_addr = AW'(5);
    step();
    set_idle();
    chk("swap_rd_addr", 32'(bus.o_mem_addr), 32'(DBL ? 32768 + 5 : 5));
    wr_beat(9, 8'h5A, 1'b0, 1'b0);
    chk("swap_wr_addr", 32'(bus.o_mem_addr), 32'd9);
    chk("swap_wr_we",   32'(bus.o_mem_we), 32'd1);

    // ---------------- stale counter ----------------
    pulse_frame(3);
    chk("stale_3", 32'(bus.o_stale_cnt), DBL ? 32'd3 : 32'd0);
    pulse_frame(297);
    chk("stale_sat", 32'(bus.o_stale_cnt), DBL ? 32'd255 : 32'd0);
    chk("stale_bank_kept", 32'(bus.o_disp_bank), 32'(DBL));

    // ---------------- last beat coincident with frame start ----------------
    do_reset();
    wr_beat(3, 8'h77, 1'b1, 1'b1);
    chk("coinc_we",        32'(bus.o_mem_we), 32'd1);
    chk("coinc_addr",      32'(bus.o_mem_addr), 32'(WB + 3));
    chk("coinc_disp_bank", 32'(bus.o_disp_bank), 32'(DBL));
    chk("coinc_stale",     32'(bus.o_stale_cnt), 32'd0);
    chk("coinc_wr_ready",  32'(bus.o_wr_ready), 32'd1);
    wr_beat(4, 8'h78, 1'b0, 1'b0);
    chk("coinc_next_addr", 32'(bus.o_mem_addr), 32'd4);

    // ---------------- reset aborts in-flight reads ----------------
    bus.i_rd_req = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    chk("rst_abort_valid", 32'(bus.o_rd_valid), 32'd0);
    chk("rst_abort_bank",  32'(bus.o_disp_bank), 32'd0);
    rst = 1'b0;
    bus.i_rd_req = 1'b0;
    step();
    chk("rst_abort_valid2", 32'(bus.o_rd_valid), 32'd0);
    step();

    // ---------------- randomized run vs. reference model ----------------
    do_reset();
    m_disp = 1'b0; m_wr = DBL; m_hold = 1'b0; m_err = 1'b0;
    m_stale = 0; m_en = 1'b0; m_we = 1'b0; m_addr = 0; m_wdata = 0;
    due.delete();
    e = 0;
    for (int c = 0; c < 4000; c++) begin
      r_rst           = ($urandom_range(0, 499) == 0);
      rst             = r_rst;
      bus.i_rd_req    = ($urandom_range(0, 1) == 1);
      bus.i_rd_addr   = AW'($urandom);
      bus.i_wr_valid  = ($urandom_range(0, 9) < 6);
      bus.i_wr_addr   = ($urandom_range(0, 31) == 0) ? AW'($urandom_range(PIX, 32767))
                                                     : AW'($urandom_range(0, PIX - 1));
      bus.i_wr_data   = DW'($urandom);
      bus.i_wr_last   = ($urandom_range(0, 49) == 0);
      bus.i_frame     = ($urandom_range(0, 39) == 0);
      bus.i_mem_rdata = DW'($urandom);
      #1;
      m_ready = !bus.i_rd_req && !m_hold;
      m_acc   = bus.i_wr_valid && m_ready;
      chk("rnd_wr_ready", 32'(bus.o_wr_ready), 32'(m_ready));
      @(posedge clk);
      e++;
      if (r_rst) begin
        m_disp = 1'b0; m_wr = DBL; m_hold = 1'b0; m_err = 1'b0;
        m_stale = 0; m_en = 1'b0; m_we = 1'b0; m_addr = 0; m_wdata = 0;
        due.delete();
      end else begin
        m_we = !bus.i_rd_req && m_acc && (int'(bus.i_wr_addr) < PIX);
        m_en = bus.i_rd_req || m_we;
        if (bus.i_rd_req) m_addr = (DBL && m_disp ? 32768 : 0) + int'(bus.i_rd_addr);
        else if (m_we) begin
          m_addr  = (DBL && m_wr ? 32768 : 0) + int'(bus.i_wr_addr);
          m_wdata = int'(bus.i_wr_data);
        end
        if (m_acc && int'(bus.i_wr_addr) >= PIX) m_err = 1'b1;
        if (bus.i_rd_req) due.push_back(e + LAT);
        if (DBL) begin
          if (bus.i_frame && (m_hold || (m_acc && bus.i_wr_last))) begin
            m_disp  = !m_disp;
            m_wr    = !m_wr;
            m_hold  = 1'b0;
            m_stale = 0;
          end else if (bus.i_frame) begin
            m_stale = (m_stale < 255) ? m_stale + 1 : 255;
          end else if (m_acc && bus.i_wr_last) begin
            m_hold = 1'b1;
          end
        end
      end
      #1;
      while (due.size() > 0 && due[0] < e) void'(due.pop_front());
      m_vld = (due.size() > 0 && due[0] == e);
      chk("rnd_mem_en",    32'(bus.o_mem_en),    32'(m_en));
      chk("rnd_mem_we",    32'(bus.o_mem_we),    32'(m_we));
      chk("rnd_mem_addr",  32'(bus.o_mem_addr),  32'(m_addr));
      chk("rnd_mem_wdata", 32'(bus.o_mem_wdata), 32'(m_wdata));
      chk("rnd_rd_valid",  32'(bus.o_rd_valid),  32'(m_vld));
      chk("rnd_rd_data",   32'(bus.o_rd_data),   32'(bus.i_mem_rdata));
      chk("rnd_disp_bank", 32'(bus.o_disp_bank), 32'(m_disp));
      chk("rnd_stale",     32'(bus.o_stale_cnt), 32'(m_stale));
      chk("rnd_addr_err",  32'(bus.o_addr_err),  32'(m_err));
    end
    rst = 1'b0;
    set_idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fb_access_arbiter.md
Name: fb_access_arbiter

Overview:
- Shares one single-port framebuffer BRAM between two requesters:
  - the display read path, which reads at the pixel rate with a fixed latency;
  - the thermal-sensor write path, a 160x120 frame source with a valid/ready handshake.
- The display always wins. The writer is given the cycles the display does not use.
- Manages ping-pong banks so the display never shows a half-written sensor frame.
- Sits between the sensor frame assembler, the framebuffer pixel generator and the BRAM.

Parameters:
- p_addr_width, 15, pixel address width within one bank.
- p_data_width, 8, pixel data width.
- p_fb_pixels, 19200, valid pixels per bank (160*120).
- p_rd_latency, 1, BRAM read latency in cycles.

Ports:
- i_clk_pixel  in  1  pixel clock.
- i_rst  in  1  synchronous, active-high reset.
- i_frame  in  1  display frame-start pulse.
- i_rd_req  in  1  display read request.
- i_rd_addr  in  p_addr_width  display pixel address.
- o_rd_valid  out  1  read data valid.
- o_rd_data  out  p_data_width  read data.
- i_wr_valid  in  1  writer beat valid.
- i_wr_addr  in  p_addr_width  writer pixel address.
- i_wr_data  in  p_data_width  writer pixel data.
- i_wr_last  in  1  last beat of the sensor frame.
- o_wr_ready  out  1  writer may transfer.
- o_mem_en  out  1  BRAM enable.
- o_mem_we  out  1  BRAM write enable.
- o_mem_addr  out  p_addr_width+1  BRAM address; MSB is the bank bit.
- o_mem_wdata  out  p_data_width  BRAM write data.
- i_mem_rdata  in  p_data_width  BRAM read data.
- o_disp_bank  out  1  bank being displayed.
- o_stale_cnt  out  8  count of display frames shown without a new frame; saturates at 255.
- o_addr_err  out  1  sticky: writer address out of range.

Behaviour:
- Reset values:
  - all outputs 0, except o_wr_ready = 1 (follows its combinational term);
  - disp_bank = 0, wr_bank = 1, state WRITE;
  - read-valid pipeline cleared, pending swap cleared.
  - A reset during any operation aborts in-flight reads: no o_rd_valid pulses after reset.
- Arbitration:
  - o_wr_ready = !i_rd_req && state==WRITE, combinational.
  - Write accepted when i_wr_valid && o_wr_ready.
  - Display requests are never stalled.
- Memory command, registered (one cycle after the request):
  - Read: o_mem_en=1, o_mem_we=0, o_mem_addr={disp_bank, i_rd_addr}.
  - Accepted write: o_mem_en=1, o_mem_we=1, o_mem_addr={wr_bank, i_wr_addr}, o_mem_wdata=i_wr_data.
  - Otherwise o_mem_en=0, o_mem_we=0. Address and data outputs hold their last value.
- Read latency:
  - o_rd_valid asserts exactly 1+p_rd_latency cycles after i_rd_req, via a shift register.
  - o_rd_data = i_mem_rdata, passed through combinationally and aligned with o_rd_valid.
  - Back-to-back requests give back-to-back valids.
- Address range:
  - An accepted write with i_wr_addr >= p_fb_pixels is consumed: o_mem_we stays 0 and o_addr_err is set.
  - o_addr_err clears only on reset.
  - Read addresses are not checked.
- State machine:
  - WRITE: accepting writes. An accepted beat with i_wr_last moves to HOLD.
  - HOLD: o_wr_ready=0, waiting for i_frame. On i_frame: swap disp_bank and wr_bank, go to WRITE.
- Simultaneous accepted i_wr_last and i_frame:
  - the swap happens at that edge;
  - the last beat's write command uses the pre-swap wr_bank, so it lands in the completed frame;
  - state goes to WRITE.
- Stale counter:
  - i_frame in WRITE: o_stale_cnt increments, saturating at 255.
  - i_frame that performs a swap: o_stale_cnt clears to 0.
- o_disp_bank changes only at an i_frame edge. Reads issued in the same cycle as a swap use the pre-swap bank.

Optional Feature:
- FB_DOUBLE_BUFFER_EN
  - Defined: ping-pong behaviour as above.
  - Undefined: single bank.
    - Bank bit tied to 0 and o_disp_bank = 0.
    - HOLD is never entered; i_wr_last is ignored, so the writer is throttled only by display priority.
    - o_stale_cnt is held at 0.
  - Port list is identical in both builds.

Test Plan:
- Reset, then i_rd_req with i_rd_addr=5 held 3 cycles -> o_mem_addr=0x0005 (bank 0) one cycle later. o_rd_valid high for 3 cycles, starting 2 cycles after the first request (p_rd_latency=1).
- i_wr_valid and i_rd_req held together for 4 cycles -> o_wr_ready=0 throughout and no write issued. Drop i_rd_req -> write accepted next cycle, o_mem_addr MSB=1.
- Write 19200 beats with i_wr_last on the final beat -> o_wr_ready=0 (HOLD). Next i_frame -> o_disp_bank=1, reads hit bank 1, writes go to bank 0, o_stale_cnt=0.
- Three i_frame pulses with no write activity -> o_stale_cnt=3. 300 pulses -> o_stale_cnt=255.
- Accepted write with i_wr_addr=19200 -> o_mem_we stays 0 and o_addr_err=1. The error persists until reset.
- i_wr_last accepted in the same cycle as i_frame -> last write has MSB=1 (old wr_bank), o_disp_bank=1 next cycle, state WRITE. Assert i_rst mid-frame -> o_rd_valid=0 and o_disp_bank=0 the following cycle.
